// File: rtl/mem_block_mover_if.sv
// Command/status and memory-port bundle for the block mover engine.
// The master modport is the engine's view; slave is the control path and RAM side.
interface mem_block_mover_if #(
  parameter int ADDR_SIZE = 16,
  parameter int WORD_SIZE = 16
);
  // command path from the control unit
  logic                 start;
  logic                 mode;
  logic [ADDR_SIZE-1:0] src;
  logic [ADDR_SIZE-1:0] dst;
  logic [ADDR_SIZE-1:0] len;
  logic [WORD_SIZE-1:0] fill_val;
  logic                 abort;
  // status back to the control unit
  logic                 busy;
  logic                 done;
  logic [ADDR_SIZE-1:0] remaining;
  // single-port memory, asynchronous read
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic                 mem_we;
  logic [WORD_SIZE-1:0] mem_rdata;

  modport master (
    input  start, mode, src, dst, len, fill_val, abort, mem_rdata,
    output busy, done, remaining, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    output start, mode, src, dst, len, fill_val, abort, mem_rdata,
    input  busy, done, remaining, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/mem_block_mover.sv
// Block copy / block fill engine for the single-port main memory.
// Copies run word-serially as READ/WRITE pairs, fills as back-to-back WRITEs.
// Every memory-side output is decoded from registered state only.
module mem_block_mover #(
  parameter int ADDR_SIZE = 16,
  parameter int WORD_SIZE = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_block_mover_if.master     bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    FIN   = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_SIZE-1:0] src_q, src_d;
  logic [ADDR_SIZE-1:0] dst_q, dst_d;
  logic [ADDR_SIZE-1:0] cnt_q, cnt_d;
  logic [WORD_SIZE-1:0] fval_q, fval_d;
  logic [WORD_SIZE-1:0] data_q, data_d;
  logic                 mode_q, mode_d;

  // State and datapath registers; reset drops any command in flight at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      fval_q  <= '0;
      data_q  <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      fval_q  <= fval_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
    end
  end

  // Next-state and datapath updates; abort overrides every other transition.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    fval_d  = fval_q;
    data_d  = data_q;
    mode_d  = mode_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          src_d  = bus.src;
          dst_d  = bus.dst;
          cnt_d  = bus.len;
          fval_d = bus.fill_val;
          mode_d = bus.mode;
          if (bus.len == '0) begin
            state_d = FIN;
          end else if (bus.mode) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        data_d  = bus.mem_rdata;
        src_d   = src_q + 1'b1;
        state_d = WRITE;
      end
      WRITE: begin
        dst_d = dst_q + 1'b1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == ADDR_SIZE'(1)) begin
          state_d = FIN;
        end else if (mode_q) begin
          state_d = WRITE;
        end else begin
          state_d = READ;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // the write enabled this cycle still lands; only the sequencing stops
    if (bus.abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == FIN);
  assign bus.remaining = (state_q == IDLE) ? '0 : cnt_q;
  assign bus.mem_we    = (state_q == WRITE);
  assign bus.mem_addr  = (state_q == READ)  ? src_q :
                         (state_q == WRITE) ? dst_q : '0;
  assign bus.mem_wdata = (state_q != WRITE) ? '0 :
                         (mode_q ? fval_q : data_q);

endmodule

// File: tb/tb_mem_block_mover.sv
// Bench for mem_block_mover: behavioural RAM, reference memory model feeding a
// write scoreboard, a command table plus hand-written abort/reset/start cases.
module tb_mem_block_mover;
  localparam int AW = 16;
  localparam int WW = 16;
  localparam int BIG = 1 << 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_block_mover_if #(.ADDR_SIZE(AW), .WORD_SIZE(WW)) bus_if ();

  mem_block_mover #(.ADDR_SIZE(AW), .WORD_SIZE(WW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  // behavioural RAM: asynchronous read, write at the clock edge
  logic [WW-1:0] mem     [0:65535];
  logic [WW-1:0] ref_mem [0:65535];
  assign bus_if.mem_rdata = mem[bus_if.mem_addr];
  always @(posedge clk) if (rst_n && bus_if.mem_we) mem[bus_if.mem_addr] <= bus_if.mem_wdata;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [WW-1:0] data;
  } wr_t;
  wr_t exp_q[$];
  wr_t exp_e;

  int pass_cnt = 0;
  int total_cnt = 0;
  int wr_cnt = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
      $display("ok   %s: 0x%0h", name, act);
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // write scoreboard: every enabled write must match the next expected one
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_if.done) done_cnt++;
      if (bus_if.mem_we) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none",
                   bus_if.mem_addr, bus_if.mem_wdata);
        end else begin
          exp_e = exp_q.pop_front();
          check("write", {bus_if.mem_addr, bus_if.mem_wdata}, exp_e);
        end
      end
    end
  end

  // reference: forward, word-serial copy/fill on ref_mem, first max_w writes
  task automatic model(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                       input logic [AW-1:0] l, input logic [WW-1:0] f, input int max_w);
    logic [AW-1:0] sp = s;
    logic [AW-1:0] dp = d;
    logic [WW-1:0] v;
    for (int i = 0; i < int'(l) && i < max_w; i++) begin
      v = m ? f : ref_mem[sp];
      ref_mem[dp] = v;
      exp_q.push_back({dp, v});
      sp = sp + 1'b1;
      dp = dp + 1'b1;
    end
  endtask

  task automatic issue(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                       input logic [AW-1:0] l, input logic [WW-1:0] f);
    @(negedge clk);
    bus_if.mode = m; bus_if.src = s; bus_if.dst = d; bus_if.len = l; bus_if.fill_val = f;
    bus_if.start = 1'b1;
    @(posedge clk);
    #1 bus_if.start = 1'b0;
  endtask

  // cycles after the start edge until done is seen (-1 if it never comes)
  task automatic wait_done(output int lat);
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (bus_if.done) begin
        lat = c;
        break;
      end
    end
  endtask

  typedef struct {
    string         name;
    logic          mode;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [AW-1:0] len;
    logic [WW-1:0] fval;
    int            lat;
    int            nwr;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int lat;
    int mism;
    vecs[0] = '{"copy4",       1'b0, 16'h0010, 16'h0040, 16'd4, 16'h0000, 9, 4};
    vecs[1] = '{"copy_srcwrap",1'b0, 16'hFFFF, 16'h0200, 16'd2, 16'h0000, 5, 2};
    vecs[2] = '{"fill_wrap",   1'b1, 16'h0000, 16'hFFFE, 16'd4, 16'h5A5A, 5, 4};
    vecs[3] = '{"len0",        1'b0, 16'h0010, 16'h0080, 16'd0, 16'h0000, 1, 0};
    vecs[4] = '{"overlap",     1'b0, 16'h0020, 16'h0021, 16'd3, 16'h0000, 7, 3};
    vecs[5] = '{"fill1",       1'b1, 16'h0000, 16'h0100, 16'd1, 16'h1234, 2, 1};

    bus_if.start = 1'b0; bus_if.mode = 1'b0; bus_if.abort = 1'b0;
    bus_if.src = '0; bus_if.dst = '0; bus_if.len = '0; bus_if.fill_val = '0;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    mem[16'h0010] = 16'h00A1; mem[16'h0011] = 16'h00B2; mem[16'h0012] = 16'h00C3; mem[16'h0013] = 16'h00D4;
    mem[16'h0020] = 16'h0001; mem[16'h0021] = 16'h0002; mem[16'h0022] = 16'h0003; mem[16'h0023] = 16'h0004;
    mem[16'hFFFF] = 16'hBEEF; mem[16'h0000] = 16'hCAFE;
    for (int i = 0; i < 65536; i++) ref_mem[i] = mem[i];

    // outputs under reset
    #1;
    check("rst_busy", 32'(bus_if.busy), 0);
    check("rst_done", 32'(bus_if.done), 0);
    check("rst_we", 32'(bus_if.mem_we), 0);
    check("rst_addr", 32'(bus_if.mem_addr), 0);
    check("rst_wdata", 32'(bus_if.mem_wdata), 0);
    check("rst_remaining", 32'(bus_if.remaining), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // table-driven commands
    for (int v = 0; v < 6; v++) begin
      wr_cnt = 0; done_cnt = 0;
      model(vecs[v].mode, vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].fval, BIG);
      issue(vecs[v].mode, vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].fval);
      @(negedge clk);
      check({vecs[v].name, "_busy_c1"}, 32'(bus_if.busy), 1);
      check({vecs[v].name, "_remaining_c1"}, 32'(bus_if.remaining), 32'(vecs[v].len));
      if (bus_if.done) lat = 1;
      else begin
        wait_done(lat);
        if (lat > 0) lat = lat + 1;
      end
      check({vecs[v].name, "_latency"}, 32'(lat), 32'(vecs[v].lat));
      @(negedge clk);
      check({vecs[v].name, "_busy_after"}, 32'(bus_if.busy), 0);
      check({vecs[v].name, "_writes"}, 32'(wr_cnt), 32'(vecs[v].nwr));
      check({vecs[v].name, "_pending"}, 32'(exp_q.size()), 0);
    end
    check("copy_m40", 32'(mem[16'h0040]), 32'h00A1);
    check("copy_m43", 32'(mem[16'h0043]), 32'h00D4);
    check("srcwrap_m200", 32'(mem[16'h0200]), 32'hBEEF);
    check("srcwrap_m201", 32'(mem[16'h0201]), 32'hCAFE);
    check("fill_mFFFE", 32'(mem[16'hFFFE]), 32'h5A5A);
    check("fill_m0001", 32'(mem[16'h0001]), 32'h5A5A);
    check("overlap_m21", 32'(mem[16'h0021]), 32'h0001);
    check("overlap_m23", 32'(mem[16'h0023]), 32'h0001);

    // abort in the third WRITE of an 8-word fill, then restart at once
    wr_cnt = 0; done_cnt = 0;
    model(1'b1, 16'h0000, 16'h0300, 16'd8, 16'h7777, 3);
    issue(1'b1, 16'h0000, 16'h0300, 16'd8, 16'h7777);
    @(negedge clk); @(negedge clk); @(negedge clk);
    bus_if.abort = 1'b1;
    @(negedge clk);
    bus_if.abort = 1'b0;
    check("abort_busy", 32'(bus_if.busy), 0);
    check("abort_remaining", 32'(bus_if.remaining), 0);
    check("abort_writes", 32'(wr_cnt), 3);
    check("abort_no_done", 32'(done_cnt), 0);
    check("abort_pending", 32'(exp_q.size()), 0);
    model(1'b1, 16'h0000, 16'h0310, 16'd1, 16'h1111, BIG);
    bus_if.mode = 1'b1; bus_if.dst = 16'h0310; bus_if.len = 16'd1; bus_if.fill_val = 16'h1111;
    bus_if.start = 1'b1;
    @(posedge clk);
    #1 bus_if.start = 1'b0;
    wait_done(lat);
    check("restart_latency", 32'(lat), 2);
    check("abort_m303", 32'(mem[16'h0303]), 0);
    check("restart_m310", 32'(mem[16'h0310]), 32'h1111);

    // start pulse while busy must be ignored
    wr_cnt = 0;
    model(1'b0, 16'h0010, 16'h0050, 16'd4, 16'h0000, BIG);
    issue(1'b0, 16'h0010, 16'h0050, 16'd4, 16'h0000);
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 2) begin
        bus_if.start = 1'b1; bus_if.mode = 1'b1; bus_if.dst = 16'h0600;
        bus_if.len = 16'd1; bus_if.fill_val = 16'hDEAD;
      end
      if (c == 3) bus_if.start = 1'b0;
      if (bus_if.done) begin
        lat = c;
        break;
      end
    end
    check("ignstart_latency", 32'(lat), 9);
    @(negedge clk); @(negedge clk); @(negedge clk);
    check("ignstart_busy", 32'(bus_if.busy), 0);
    check("ignstart_writes", 32'(wr_cnt), 4);
    check("ignstart_m600", 32'(mem[16'h0600]), 0);

    // asynchronous reset during the second READ of a copy
    wr_cnt = 0;
    model(1'b0, 16'h0010, 16'h0060, 16'd4, 16'h0000, 1);
    issue(1'b0, 16'h0010, 16'h0060, 16'd4, 16'h0000);
    @(negedge clk); @(negedge clk); @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(bus_if.busy), 0);
    check("arst_addr", 32'(bus_if.mem_addr), 0);
    check("arst_we", 32'(bus_if.mem_we), 0);
    check("arst_remaining", 32'(bus_if.remaining), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    check("arst_writes", 32'(wr_cnt), 1);
    check("arst_busy_after", 32'(bus_if.busy), 0);
    check("arst_m61", 32'(mem[16'h0061]), 0);
    check("arst_pending", 32'(exp_q.size()), 0);

    // whole memory against the reference model
    mism = 0;
    for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) mism++;
    check("mem_vs_model", 32'(mism), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_block_mover.md
# mem_block_mover

Bus-master engine that drives the single-port, asynchronous-read, synchronous-write main memory. It takes block-copy or block-fill commands from the CPU control path and executes them word by word over the memory's address, write-data, write-enable and read-data port. It sits between the control unit and the RAM port mux, and owns the port only while busy.

## Interface
- addrSize, 16, memory address width; all pointers and lengths use this width
- wordSize, 16, memory word width
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  command strobe; sampled only when idle
- mode  in  1  0 = copy, 1 = fill
- src  in  addrSize  copy source start address (ignored in fill)
- dst  in  addrSize  destination start address
- len  in  addrSize  word count; 0 is legal
- fill_val  in  wordSize  fill value (ignored in copy)
- abort  in  1  cancel the running command
- busy  out  1  high while a command is in progress
- done  out  1  one-cycle pulse on normal completion
- remaining  out  addrSize  words not yet written
- mem_addr  out  addrSize  memory address
- mem_wdata  out  wordSize  memory write data
- mem_we  out  1  memory write enable
- mem_rdata  in  wordSize  asynchronous memory read data

## Operation
- States: IDLE, READ, WRITE, FIN.
- IDLE: start=1 latches src_ptr<=src, dst_ptr<=dst, cnt<=len, fval<=fill_val and the mode. Next state: FIN if len=0; READ if copy; WRITE if fill. start=0 holds IDLE.
- READ (copy only): mem_addr=src_ptr, mem_we=0. At the edge, buf<=mem_rdata, src_ptr<=src_ptr+1, next state WRITE.
- WRITE: mem_addr=dst_ptr, mem_wdata=buf (copy) or fval (fill), mem_we=1. At the edge, dst_ptr<=dst_ptr+1, cnt<=cnt-1. Next state: FIN if cnt=1; otherwise READ (copy) or WRITE (fill).
- FIN: done=1, mem_we=0. Next state IDLE.
- Pointers increment modulo 2^addrSize. Wrap from all-ones to 0 is legal and silent.
- Copy is forward-only and word-serial. If dst lies inside (src, src+len), the source is overwritten before it is read. This replication is the defined behaviour, not an error.
- start is ignored while busy and does not queue.
- abort=1 in READ, WRITE or FIN forces IDLE at the next edge. done is not pulsed. A write already enabled in that cycle completes. abort in IDLE has no effect. abort has priority over start.
- busy=1 in READ, WRITE and FIN. remaining=cnt, and is 0 in IDLE.
- Outputs depend only on registered state. There is no combinational path from start, abort or the command inputs to any mem_* output.
- In IDLE: mem_addr=0, mem_wdata=0, mem_we=0.

## Timing
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, mem_we=0, mem_addr=0, mem_wdata=0, remaining=0, all pointers and buf 0. Reset mid-command drops the command immediately, with no further write.
- start sampled at edge k: busy=1 from cycle k+1.
- Copy of N≥1 words: 2N cycles of READ/WRITE, then FIN. done is high in cycle k+1+2N. busy drops, and start is accepted again, at edge k+2+2N.
- Fill of N≥1 words: N WRITE cycles, with done in cycle k+1+N.
- len=0: FIN in cycle k+1 (done=1), zero writes.
- Write i lands at the end of its WRITE cycle. mem_rdata is sampled at the end of READ.

## Test plan
- Copy: preload mem[0x10..0x13]=A1,B2,C3,D4; start copy src=0x10 dst=0x40 len=4 -> mem[0x40..0x43]=A1,B2,C3,D4, done exactly 9 cycles after start, 4 mem_we pulses.
- Fill with wrap: dst=0xFFFE len=4 fill_val=0x5A5A -> mem[0xFFFE], mem[0xFFFF], mem[0x0000], mem[0x0001]=0x5A5A, done 5 cycles after start.
- len=0 with start -> done the next cycle, mem_we never asserted, busy high for 1 cycle.
- Overlap: mem[0x20..0x23]=1,2,3,4; copy src=0x20 dst=0x21 len=3 -> mem[0x21..0x23]=1,1,1.
- Abort: fill len=8 with abort in the 3rd WRITE cycle -> exactly 3 words written, no done, busy low the next cycle, remaining=0; a new start is accepted immediately.
- Async reset mid-copy plus ignored start: rst_n low mid-command -> all outputs 0 without a clock edge; a start pulse while busy leaves the pointers and the completion timing of the running command unchanged.
